// File: rtl/cr16_pkg.sv
// Shared constants, PSR bit positions and clear-sequencer state encoding
// for the CR16 register file.
package cr16_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int FLAG_WIDTH = 5;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  // PSR bit order matches the ALU flags bus
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  function automatic logic [FLAG_WIDTH-1:0] psr_merge(
    input logic [FLAG_WIDTH-1:0] psr,
    input logic [FLAG_WIDTH-1:0] flags,
    input logic [FLAG_WIDTH-1:0] mask
  );
    return (psr & ~mask) | (flags & mask);
  endfunction

endpackage

// File: rtl/cr16_reg_clear_seq.sv
// Post-reset clear sequencer: walks every register index once, writing zero,
// then parks in READY until the next reset.
module cr16_reg_clear_seq
  import cr16_pkg::*;
#(
  parameter int ADDR_WIDTH = cr16_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  clr_state_t            state;
  clr_state_t            state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Counter holds at the last index once READY, so it never wraps.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_we       = 1'b0;
    busy         = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        if (clr_cnt == '1) begin
          state_next = READY;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign clr_addr = clr_cnt;

endmodule

// File: rtl/cr16_reg_file.sv
// CR16 register file (2 read / 1 write) plus PSR. Optional same-cycle write
// forwarding is enabled by defining CR16_REGFILE_BYPASS_EN.
module cr16_reg_file
  import cr16_pkg::*;
#(
  parameter int DATA_WIDTH = cr16_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cr16_pkg::ADDR_WIDTH,
  parameter int FLAG_WIDTH = cr16_pkg::FLAG_WIDTH
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  I_WR_EN,
  input  logic [ADDR_WIDTH-1:0] I_WR_ADDR,
  input  logic [DATA_WIDTH-1:0] I_WR_DATA,
  input  logic [ADDR_WIDTH-1:0] I_RD_ADDR_A,
  input  logic [ADDR_WIDTH-1:0] I_RD_ADDR_B,
  output logic [DATA_WIDTH-1:0] O_RD_DATA_A,
  output logic [DATA_WIDTH-1:0] O_RD_DATA_B,
  input  logic [FLAG_WIDTH-1:0] I_FLAGS,
  input  logic [FLAG_WIDTH-1:0] I_FLAGS_WR_MASK,
  output logic [FLAG_WIDTH-1:0] O_FLAGS,
  output logic                  O_BUSY
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [FLAG_WIDTH-1:0] psr;

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  cr16_reg_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk     (I_CLK),
    .rst     (I_RESET),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  // While clearing, the sequencer owns the write port; host writes are dropped.
  always_comb begin
    we    = I_WR_EN;
    waddr = I_WR_ADDR;
    wdata = I_WR_DATA;
    if (busy) begin
      we    = clr_we;
      waddr = clr_addr;
      wdata = '0;
    end
  end

  // No reset on the array so it can map onto distributed RAM.
  always_ff @(posedge I_CLK) begin
    if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      psr <= '0;
    end else if (!busy) begin
      psr <= psr_merge(psr, I_FLAGS, I_FLAGS_WR_MASK);
    end
  end

  always_comb begin
    O_RD_DATA_A = regs[I_RD_ADDR_A];
    O_RD_DATA_B = regs[I_RD_ADDR_B];
    O_FLAGS     = psr;
`ifdef CR16_REGFILE_BYPASS_EN
    if (I_WR_EN && (I_WR_ADDR == I_RD_ADDR_A)) begin
      O_RD_DATA_A = I_WR_DATA;
    end
    if (I_WR_EN && (I_WR_ADDR == I_RD_ADDR_B)) begin
      O_RD_DATA_B = I_WR_DATA;
    end
    O_FLAGS = psr_merge(psr, I_FLAGS, I_FLAGS_WR_MASK);
`endif
    if (busy) begin
      O_RD_DATA_A = '0;
      O_RD_DATA_B = '0;
      O_FLAGS     = psr;
    end
  end

  assign O_BUSY = busy;

endmodule
